// File: rtl/switch_event_debouncer_pkg.sv
// Shared types and default limits for the switch event debouncer.
// The optional SWITCH_LONG_PRESS_EN macro, when defined, enables the long-press hold counter.
package switch_event_debouncer_pkg;

    // Debounce FSM state, one per channel
    typedef enum logic [1:0] {
        StReleased     = 2'b00,
        StCheckPress   = 2'b01,
        StPressed      = 2'b10,
        StCheckRelease = 2'b11
    } sw_state_e;

    localparam int unsigned DefaultNumSw          = 4;
    localparam int unsigned DefaultDebounceLimit  = 250000;   // 10 ms @ 25 MHz
    localparam int unsigned DefaultLongPressLimit = 25000000; // 1 s @ 25 MHz

    // The debounced level is high while a press is accepted and not yet released
    function automatic logic is_active(sw_state_e s);
        return (s == StPressed) || (s == StCheckRelease);
    endfunction

endpackage

// File: rtl/switch_event_debouncer_debounce_channel.sv
// One switch channel: 2-flop synchronizer, debounce FSM with counter, registered level
// and press/release strobes. Long-press hold counter exists only with SWITCH_LONG_PRESS_EN.
module switch_event_debouncer_debounce_channel
    import switch_event_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT   = DefaultDebounceLimit,
    parameter int unsigned LONG_PRESS_LIMIT = DefaultLongPressLimit
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic switch_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o
);

    localparam int unsigned      CntW    = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CntW-1:0]  CntLast = CntW'(DEBOUNCE_LIMIT - 1);

    logic            sync1_q, sync2_q;
    sw_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, release_q;

    // Two-flop synchronizer for the asynchronous switch pin
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= switch_i;
            sync2_q <= sync1_q;
        end
    end

    // FSM state and debounce counter registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StReleased;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: a change is accepted only after DEBOUNCE_LIMIT agreeing synced samples
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StReleased: begin
                if (sync2_q) begin
                    state_d = StCheckPress;
                    cnt_d   = CntW'(1);
                end
            end
            StCheckPress: begin
                if (!sync2_q) begin
                    state_d = StReleased;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StPressed: begin
                if (!sync2_q) begin
                    state_d = StCheckRelease;
                    cnt_d   = CntW'(1);
                end
            end
            StCheckRelease: begin
                if (sync2_q) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StReleased;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StReleased;
                cnt_d   = '0;
            end
        endcase
    end

    // Level follows the accepted state; strobes mark its edges in the same cycle
    always_comb begin
        level_d = is_active(state_q);
    end

    // Output register stage: level and one-cycle edge strobes
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            press_q   <= level_d & ~level_q;
            release_q <= ~level_d & level_q;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef SWITCH_LONG_PRESS_EN
    localparam int unsigned       HoldW    = $clog2(LONG_PRESS_LIMIT + 1);
    localparam logic [HoldW-1:0]  HoldLast = HoldW'(LONG_PRESS_LIMIT - 1);
    localparam logic [HoldW-1:0]  HoldMax  = HoldW'(LONG_PRESS_LIMIT);

    logic [HoldW-1:0] hold_q, hold_d;
    logic             long_q, long_d;

    // Hold counter runs while pressed, saturates past the strobe point so each press fires once
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (is_active(state_q)) begin
            if (hold_q != HoldMax) begin
                hold_d = hold_q + HoldW'(1);
            end
            long_d = (hold_q == HoldLast);
        end else begin
            hold_d = '0;
        end
    end

    // Hold counter and long-press strobe registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_press_o = long_q;
`else
    logic unused_long_limit;
    assign unused_long_limit = ^LONG_PRESS_LIMIT;
    assign long_press_o      = 1'b0;
`endif

endmodule

// File: rtl/switch_event_debouncer.sv
// Switch event debouncer top: NUM_SW independent debounce channels producing a clean level,
// press/release strobes and (with SWITCH_LONG_PRESS_EN defined) a long-press strobe per switch.
module switch_event_debouncer
    import switch_event_debouncer_pkg::*;
#(
    parameter int unsigned NUM_SW           = DefaultNumSw,
    parameter int unsigned DEBOUNCE_LIMIT   = DefaultDebounceLimit,
    parameter int unsigned LONG_PRESS_LIMIT = DefaultLongPressLimit
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [NUM_SW-1:0] i_Switch,
    output logic [NUM_SW-1:0] o_Level,
    output logic [NUM_SW-1:0] o_Press_Pulse,
    output logic [NUM_SW-1:0] o_Release_Pulse,
    output logic [NUM_SW-1:0] o_Long_Press
);

    logic [NUM_SW-1:0] level;
    logic [NUM_SW-1:0] press;
    logic [NUM_SW-1:0] release_evt;
    logic [NUM_SW-1:0] long_press;

    for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
        switch_event_debouncer_debounce_channel #(
            .DEBOUNCE_LIMIT  (DEBOUNCE_LIMIT),
            .LONG_PRESS_LIMIT(LONG_PRESS_LIMIT)
        ) u_ch (
            .clk_i       (i_Clk),
            .rst_ni      (i_Rst_L),
            .switch_i    (i_Switch[g]),
            .level_o     (level[g]),
            .press_o     (press[g]),
            .release_o   (release_evt[g]),
            .long_press_o(long_press[g])
        );
    end

    assign o_Level         = level;
    assign o_Press_Pulse   = press;
    assign o_Release_Pulse = release_evt;
    assign o_Long_Press    = long_press;

endmodule

// File: tb/tb_switch_event_debouncer.sv
// Bench for switch_event_debouncer with DEBOUNCE_LIMIT=4, LONG_PRESS_LIMIT=10, NUM_SW=4.
// Expectations for the optional SWITCH_LONG_PRESS_EN feature follow the same macro.
module tb_switch_event_debouncer;

  localparam int unsigned NumSw = 4;
  localparam int unsigned TimeoutNs = 100000;

`ifdef SWITCH_LONG_PRESS_EN
  localparam logic [3:0] LongCh0 = 4'h1;
`else
  localparam logic [3:0] LongCh0 = 4'h0;
`endif

  typedef struct {
    string       name;
    logic        rst_n;
    logic [3:0]  sw;
    int unsigned cycles;
    logic [3:0]  lvl;
    logic [3:0]  prs;
    logic [3:0]  rel;
    logic [3:0]  lng;
  } vec_t;

  typedef struct {
    string       name;
    int unsigned cyc;
    logic [15:0] val;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [NumSw-1:0] sw;
  logic [NumSw-1:0] o_level, o_press, o_release, o_long;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t mon_e;
  exp_t drv_e;
  logic [15:0] got;
  int n_checks;
  int n_pass;
  bit done;

  switch_event_debouncer #(
    .NUM_SW          (NumSw),
    .DEBOUNCE_LIMIT  (4),
    .LONG_PRESS_LIMIT(10)
  ) dut (
    .i_Clk          (clk),
    .i_Rst_L        (rst_n),
    .i_Switch       (sw),
    .o_Level        (o_level),
    .o_Press_Pulse  (o_press),
    .o_Release_Pulse(o_release),
    .o_Long_Press   (o_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input string name, input logic r, input logic [3:0] s,
                              input int unsigned n, input logic [3:0] l, input logic [3:0] p,
                              input logic [3:0] rl, input logic [3:0] lg);
    vec_t v;
    v.name = name; v.rst_n = r; v.sw = s; v.cycles = n;
    v.lvl = l; v.prs = p; v.rel = rl; v.lng = lg;
    vecs.push_back(v);
  endfunction

  // Monitor: compare DUT outputs away from the active edge against the scoreboard
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      got   = {o_level, o_press, o_release, o_long};
      n_checks++;
      if (got !== mon_e.val) begin
        $display("FAIL %s edge %0d: got lvl=%h prs=%h rel=%h lng=%h, want lvl=%h prs=%h rel=%h lng=%h",
                 mon_e.name, mon_e.cyc, got[15:12], got[11:8], got[7:4], got[3:0],
                 mon_e.val[15:12], mon_e.val[11:8], mon_e.val[7:4], mon_e.val[3:0]);
      end else begin
        n_pass++;
      end
    end
  end

  // Watchdog: the stimulus must complete within a bounded time
  initial begin
    done = 1'b0;
    #(TimeoutNs);
    if (!done) begin
      $display("FAIL timeout: stimulus did not complete within %0d ns", TimeoutNs);
      $finish;
    end
  end

  initial begin
    logic [3:0] prev_lvl;
    n_checks = 0;
    n_pass   = 0;
    prev_lvl = 4'h0;

    // name, rst_n, sw, cycles, final lvl, prs, rel, lng (intermediate edges: no strobes)
    add("reset",           1'b0, 4'hF, 3, 4'h0, 4'h0, 4'h0, 4'h0);
    add("rst_rel_press",   1'b1, 4'hF, 7, 4'hF, 4'hF, 4'h0, 4'h0);
    add("all_release",     1'b1, 4'h0, 7, 4'h0, 4'h0, 4'hF, 4'h0);
    add("ch0_press",       1'b1, 4'h1, 7, 4'h1, 4'h1, 4'h0, 4'h0);
    add("ch0_release",     1'b1, 4'h0, 7, 4'h0, 4'h0, 4'h1, 4'h0);
    add("ch1_short",       1'b1, 4'h2, 3, 4'h0, 4'h0, 4'h0, 4'h0);
    add("ch1_settle",      1'b1, 4'h0, 8, 4'h0, 4'h0, 4'h0, 4'h0);
    add("ch2_bounce1",     1'b1, 4'h4, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    add("ch2_bounce0",     1'b1, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    add("ch2_bounce1b",    1'b1, 4'h4, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    add("ch2_bounce0b",    1'b1, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    add("ch2_press",       1'b1, 4'h4, 7, 4'h4, 4'h4, 4'h0, 4'h0);
    add("ch2_release",     1'b1, 4'h0, 7, 4'h0, 4'h0, 4'h4, 4'h0);
    add("ch3_partial",     1'b1, 4'h8, 4, 4'h0, 4'h0, 4'h0, 4'h0);
    add("ch3_reset",       1'b0, 4'h8, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    add("ch3_restart",     1'b1, 4'h8, 7, 4'h8, 4'h8, 4'h0, 4'h0);
    add("ch3_release",     1'b1, 4'h0, 7, 4'h0, 4'h0, 4'h8, 4'h0);
    add("ch0_hold_press",  1'b1, 4'h1, 7, 4'h1, 4'h1, 4'h0, 4'h0);
    add("ch0_long",        1'b1, 4'h1, 9, 4'h1, 4'h0, 4'h0, LongCh0);
    add("ch0_glitch",      1'b1, 4'h0, 2, 4'h1, 4'h0, 4'h0, 4'h0);
    add("ch0_hold_more",   1'b1, 4'h1, 9, 4'h1, 4'h0, 4'h0, 4'h0);
    add("ch0_hold_release",1'b1, 4'h0, 7, 4'h0, 4'h0, 4'h1, 4'h0);

    for (int r = 0; r < vecs.size(); r++) begin
      rst_n = vecs[r].rst_n;
      sw    = vecs[r].sw;
      for (int c = 0; c < int'(vecs[r].cycles); c++) begin
        drv_e.name = vecs[r].name;
        drv_e.cyc  = c + 1;
        if (c == int'(vecs[r].cycles) - 1) begin
          drv_e.val = {vecs[r].lvl, vecs[r].prs, vecs[r].rel, vecs[r].lng};
        end else begin
          drv_e.val = {(vecs[r].rst_n ? prev_lvl : 4'h0), 12'h000};
        end
        @(posedge clk);
        sb.push_back(drv_e);
        #1;
      end
      // Reset state: every output must be cleared while reset is held
      if (!vecs[r].rst_n) begin
        @(negedge clk);
        #1;
        n_checks++;
        if ({o_level, o_press, o_release, o_long} !== 16'h0000) begin
          $display("FAIL %s reset state: lvl=%h prs=%h rel=%h lng=%h, want all 0",
                   vecs[r].name, o_level, o_press, o_release, o_long);
        end else begin
          n_pass++;
        end
      end
      prev_lvl = vecs[r].lvl;
    end

    repeat (2) @(negedge clk);
    #1;
    done = 1'b1;
    if (n_pass != n_checks || n_checks == 0) begin
      $display("FAIL summary: %0d/%0d checks passed", n_pass, n_checks);
    end else begin
      $display("PASS %0d/%0d checks passed", n_pass, n_checks);
    end
    $finish;
  end

endmodule
